// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage. Holds the 32x32 register file (written
// from writeback), decodes instrd into execute-stage controls and an extended
// immediate, and registers everything into the ID/EX pipeline register.
module decode_cycle #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instrd,
    input  logic [XLEN-1:0] pcd,
    input  logic [XLEN-1:0] pcplus4d,
    input  logic            regwritew,
    input  logic [4:0]      rdw,
    input  logic [XLEN-1:0] resultw,
    input  logic            flushe,
    input  logic            stalle,
    output logic [4:0]      rs1d,
    output logic [4:0]      rs2d,
    output logic            regwritee,
    output logic [1:0]      resultsrce,
    output logic            memwritee,
    output logic            jumpe,
    output logic            branche,
    output logic [2:0]      alucontrole,
    output logic            alusrce,
    output logic            illegale,
    output logic [XLEN-1:0] rd1e,
    output logic [XLEN-1:0] rd2e,
    output logic [XLEN-1:0] pce,
    output logic [XLEN-1:0] pcplus4e,
    output logic [XLEN-1:0] immexte,
    output logic [4:0]      rs1e,
    output logic [4:0]      rs2e,
    output logic [4:0]      rde
);

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_sel_t;

    logic [XLEN-1:0] rf_q [NREG];

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] rd1_s, rd2_s, imm_s;
    logic            regwrite_s, memwrite_s, jump_s, branch_s, alusrc_s, illegal_s;
    logic [1:0]      resultsrc_s, aluop_s;
    logic [2:0]      aluctl_s;
    imm_sel_t        imm_sel_s;

    assign opcode_s = instrd[6:0];
    assign funct3_s = instrd[14:12];
    assign rd_s     = instrd[11:7];
    assign rs1d     = instrd[19:15];
    assign rs2d     = instrd[24:20];

    // Register file: reset clears every entry and discards same-cycle writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (regwritew && (rdw != 5'd0)) begin
            rf_q[rdw] <= resultw;
        end else begin
            rf_q[0] <= '0;
        end
    end

    // Register reads: x0 is hard zero, writeback data bypasses the array.
    always_comb begin
        rd1_s = rf_q[rs1d];
        rd2_s = rf_q[rs2d];
        if (rs1d == 5'd0) begin
            rd1_s = '0;
        end else if (regwritew && (rdw == rs1d)) begin
            rd1_s = resultw;
        end else begin
            rd1_s = rf_q[rs1d];
        end
        if (rs2d == 5'd0) begin
            rd2_s = '0;
        end else if (regwritew && (rdw == rs2d)) begin
            rd2_s = resultw;
        end else begin
            rd2_s = rf_q[rs2d];
        end
    end

    // Main decoder: opcode to control bits, ALU op class and immediate format.
    always_comb begin
        regwrite_s  = 1'b0;
        memwrite_s  = 1'b0;
        jump_s      = 1'b0;
        branch_s    = 1'b0;
        alusrc_s    = 1'b0;
        illegal_s   = 1'b0;
        resultsrc_s = 2'b00;
        aluop_s     = 2'b00;
        imm_sel_s   = IMM_NONE;
        case (opcode_s)
            7'b0110011: begin regwrite_s = 1'b1; aluop_s = 2'b10; end
            7'b0010011: begin regwrite_s = 1'b1; alusrc_s = 1'b1; aluop_s = 2'b10; imm_sel_s = IMM_I; end
            7'b0000011: begin regwrite_s = 1'b1; alusrc_s = 1'b1; resultsrc_s = 2'b01; imm_sel_s = IMM_I; end
            7'b0100011: begin memwrite_s = 1'b1; alusrc_s = 1'b1; imm_sel_s = IMM_S; end
            7'b1100011: begin branch_s = 1'b1; aluop_s = 2'b01; imm_sel_s = IMM_B; end
            7'b1101111: begin regwrite_s = 1'b1; jump_s = 1'b1; resultsrc_s = 2'b10; imm_sel_s = IMM_J; end
            default: begin
                // The all-zero word is the fetch bubble and decodes as a NOP.
                if (instrd == 32'd0) begin
                    illegal_s = 1'b0;
                end else begin
                    illegal_s = 1'b1;
                end
            end
        endcase
        // ALU decode; unsupported funct3 on ALU ops falls back to add and flags illegal.
        aluctl_s = 3'b000;
        case (aluop_s)
            2'b00: aluctl_s = 3'b000;
            2'b01: aluctl_s = 3'b001;
            2'b10: begin
                case (funct3_s)
                    3'b000: begin
                        if (instrd[5] && instrd[30]) begin
                            aluctl_s = 3'b001;
                        end else begin
                            aluctl_s = 3'b000;
                        end
                    end
                    3'b010: aluctl_s = 3'b101;
                    3'b110: aluctl_s = 3'b011;
                    3'b111: aluctl_s = 3'b010;
                    default: begin aluctl_s = 3'b000; illegal_s = 1'b1; end
                endcase
            end
            default: aluctl_s = 3'b000;
        endcase
    end

    // Immediate generator, sign bit is always instrd[31].
    always_comb begin
        case (imm_sel_s)
            IMM_I:   imm_s = {{20{instrd[31]}}, instrd[31:20]};
            IMM_S:   imm_s = {{20{instrd[31]}}, instrd[31:25], instrd[11:7]};
            IMM_B:   imm_s = {{19{instrd[31]}}, instrd[31], instrd[7], instrd[30:25], instrd[11:8], 1'b0};
            IMM_J:   imm_s = {{11{instrd[31]}}, instrd[31], instrd[19:12], instrd[20], instrd[30:21], 1'b0};
            default: imm_s = '0;
        endcase
    end

    // ID/EX register: reset and flush insert a zero bubble, stall holds, else load.
    always_ff @(posedge clk) begin
        if (rst || flushe) begin
            regwritee   <= 1'b0;
            resultsrce  <= 2'b00;
            memwritee   <= 1'b0;
            jumpe       <= 1'b0;
            branche     <= 1'b0;
            alucontrole <= 3'b000;
            alusrce     <= 1'b0;
            illegale    <= 1'b0;
            rd1e        <= '0;
            rd2e        <= '0;
            pce         <= '0;
            pcplus4e    <= '0;
            immexte     <= '0;
            rs1e        <= 5'd0;
            rs2e        <= 5'd0;
            rde         <= 5'd0;
        end else if (!stalle) begin
            regwritee   <= regwrite_s;
            resultsrce  <= resultsrc_s;
            memwritee   <= memwrite_s;
            jumpe       <= jump_s;
            branche     <= branch_s;
            alucontrole <= aluctl_s;
            alusrce     <= alusrc_s;
            illegale    <= illegal_s;
            rd1e        <= rd1_s;
            rd2e        <= rd2_s;
            pce         <= pcd;
            pcplus4e    <= pcplus4d;
            immexte     <= imm_s;
            rs1e        <= rs1d;
            rs2e        <= rs2d;
            rde         <= rd_s;
        end else begin
            regwritee   <= regwritee;
            resultsrce  <= resultsrce;
            memwritee   <= memwritee;
            jumpe       <= jumpe;
            branche     <= branche;
            alucontrole <= alucontrole;
            alusrce     <= alusrce;
            illegale    <= illegale;
            rd1e        <= rd1e;
            rd2e        <= rd2e;
            pce         <= pce;
            pcplus4e    <= pcplus4e;
            immexte     <= immexte;
            rs1e        <= rs1e;
            rs2e        <= rs2e;
            rde         <= rde;
        end
    end

endmodule
